// File: rtl/mult_booth_seq_if.sv
// Handshake and data bundle between the execute stage and the sequential Booth multiplier.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub/skip plus arithmetic shift per cycle,
// returning the low WIDTH product bits and a signed-overflow flag.
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  mult_booth_seq_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH:0]   m_r;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic             q1_r;
  logic [CNT_W-1:0] cnt_r;

  logic             start_s;
  logic             last_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   a_shift_s;
  logic [WIDTH-1:0] q_shift_s;

  logic [WIDTH-1:0] result_r;
  logic             exception_r;
  logic             rdy_r;
  logic             busy_r;
  logic [WIDTH-1:0] result_next_s;
  logic             exception_next_s;
  logic             rdy_next_s;
  logic             busy_next_s;

  // Product overflows when its upper half is not a pure sign extension of the lower half.
  function automatic logic upper_not_sign(input logic [WIDTH-1:0] upper, input logic sign);
    return (upper != {WIDTH{sign}});
  endfunction

  assign start_s = bus.ctrl_MULT && (state_r != RUN);
  assign last_s  = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));

  // Booth add/subtract/skip followed by the arithmetic shift of {A,Q,q_1}.
  always_comb begin
    case ({q_r[0], q1_r})
      2'b01:   sum_s = a_r + m_r;
      2'b10:   sum_s = a_r + ~m_r + {{WIDTH{1'b0}}, 1'b1};
      default: sum_s = a_r;
    endcase
    a_shift_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_shift_s = {sum_s[0], q_r[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = RUN;
        else         state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (start_s) state_next_s = RUN;
        else         state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output next values; result and flag only move on the final iteration.
  always_comb begin
    busy_next_s = (state_next_s == RUN);
    if (last_s) begin
      result_next_s    = q_shift_s;
      exception_next_s = upper_not_sign(a_shift_s[WIDTH-1:0], q_shift_s[WIDTH-1]);
      rdy_next_s       = 1'b1;
    end else begin
      result_next_s    = result_r;
      exception_next_s = exception_r;
      rdy_next_s       = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_r    <= {WIDTH{1'b0}};
      exception_r <= 1'b0;
      rdy_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      result_r    <= result_next_s;
      exception_r <= exception_next_s;
      rdy_r       <= rdy_next_s;
      busy_r      <= busy_next_s;
    end
  end

  // Datapath: operand load on start, one Booth iteration per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_r   <= {(WIDTH+1){1'b0}};
      a_r   <= {(WIDTH+1){1'b0}};
      q_r   <= {WIDTH{1'b0}};
      q1_r  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      m_r   <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
      a_r   <= {(WIDTH+1){1'b0}};
      q_r   <= bus.data_operandB;
      q1_r  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      a_r   <= a_shift_s;
      q_r   <= q_shift_s;
      q1_r  <= q_r[0];
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      m_r   <= m_r;
      a_r   <= a_r;
      q_r   <= q_r;
      q1_r  <= q1_r;
      cnt_r <= cnt_r;
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_exception = exception_r;
  assign bus.data_resultRDY = rdy_r;
  assign bus.busy           = busy_r;

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Sequential radix-2 Booth multiplier for the execute stage, in parallel with the add/sub ALU.
- Each iteration adds, subtracts or skips the multiplicand in a (WIDTH+1)-bit accumulator, then shifts.
- Delivers the low WIDTH bits of the signed product with an overflow exception flag.
- Its result and ready strobe feed the execute-stage result mux and stall logic.

Parameters:
- WIDTH, 32, operand and result width in bits; two's-complement signed.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_operandA  input  WIDTH  multiplicand; sampled only on a start edge.
- data_operandB  input  WIDTH  multiplier; sampled only on a start edge.
- ctrl_MULT  input  1  start request; sampled each edge; acted on only when not busy.
- data_result  output  WIDTH  low WIDTH bits of the product; held until the next start.
- data_exception  output  1  product does not fit in WIDTH signed bits; held like data_result.
- data_resultRDY  output  1  one-cycle pulse when data_result and data_exception become valid.
- busy  output  1  high while iterating.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset); no asynchronous paths.
- Reset: state=IDLE, counter=0, A/Q/Q-1/M cleared, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset wins over ctrl_MULT on the same edge.
- Reset mid-RUN aborts the operation; no ready pulse is produced.
- Registers:
  - M: WIDTH+1 bits, sign-extended data_operandA.
  - A: WIDTH+1 bits, accumulator.
  - Q: WIDTH bits, multiplier.
  - q_1: 1 bit, Booth history.
  - cnt: CNT_W bits.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with ctrl_MULT=1:
  - Load M=sext(A_in), A=0, Q=B_in, q_1=0, cnt=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE with ctrl_MULT=0: stay in IDLE.
- RUN, one iteration per edge:
  - {Q[0],q_1}=01: A+M.
  - {Q[0],q_1}=10: A-M, computed as A + ~M + 1 in WIDTH+1 bits.
  - {Q[0],q_1}=00 or 11: A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by 1, replicating A's MSB.
  - cnt increments each iteration.
- RUN exit: after the iteration with cnt=WIDTH-1, go to DONE.
- DONE entry edge:
  - data_result=Q, i.e. the product's low WIDTH bits.
  - data_exception=1 iff the upper WIDTH bits (A[WIDTH-1:0]) are not all equal to Q[WIDTH-1].
  - data_resultRDY=1 for exactly this cycle; busy=0.
- DONE without ctrl_MULT: return to IDLE on the next edge.
- DONE with ctrl_MULT on that edge: a new start is accepted; back-to-back operation is legal.
- Latency: start sampled at edge k gives RUN on edges k+1..k+WIDTH; data_resultRDY is high in the cycle following edge k+WIDTH (33 cycles after start for WIDTH=32).
- ctrl_MULT while busy=1 is ignored: no restart, operands not resampled, in-flight result unaffected.
- Operand inputs may change freely after the start edge.
- The (WIDTH+1)-bit A avoids overflow when negating M = -2^(WIDTH-1).
- Arithmetic is exact modulo 2^(2*WIDTH) for all signed operand pairs, including zero and the most-negative value.
- data_result and data_exception change only on DONE entry or reset.

Test Plan:
- A=3, B=5, one-cycle ctrl_MULT → busy for 32 cycles; ready pulse 33 cycles after start; result=15, exception=0.
- A=-7, B=6 → result=0xFFFFFFD6 (-42), exception=0; repeat with A=6, B=-7 → identical outputs.
- A=0x00010000, B=0x00010000 → result=0x00000000, exception=1; A=0x7FFFFFFF, B=2 → result=0xFFFFFFFE, exception=1.
- A=0x80000000, B=1 → result=0x80000000, exception=0; A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1; A=0, B=0x80000000 → result=0, exception=0.
- Start A=3, B=5; pulse ctrl_MULT with A=9, B=9 at cycle 10 → ignored; result=15 at cycle 33. Then reassert ctrl_MULT in the ready cycle with A=-1, B=-1 → second result=1 after 33 more cycles.
- Start A=3, B=5; assert reset at cycle 10 → next cycle busy=0, result=0, exception=0, and no ready pulse. A new start after reset completes normally.
